// File: rtl/risc_toy_pkg.sv
// ---------------------------------------------------------------------------
// risc_toy_pkg
// Shared definitions for the RISC_TOY core, its memory responder and the
// testbenches: datapath widths, the default error read word, the opcode
// table and a small address range helper.
// No ports (package).
// ---------------------------------------------------------------------------
package risc_toy_pkg;

   localparam int XLEN    = 32;
   localparam int IADDR_W = 30;

   // Word returned by the memory for any read that falls outside the
   // implemented storage.
   localparam logic [XLEN-1:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

   // Opcode table, instruction bits [31:27].
   localparam logic [4:0] OPC_ADDI = 5'd0;
   localparam logic [4:0] OPC_ANDI = 5'd1;
   localparam logic [4:0] OPC_ORI  = 5'd2;
   localparam logic [4:0] OPC_MOVI = 5'd3;
   localparam logic [4:0] OPC_ADD  = 5'd4;
   localparam logic [4:0] OPC_SUB  = 5'd5;
   localparam logic [4:0] OPC_NEG  = 5'd6;
   localparam logic [4:0] OPC_NOT  = 5'd7;
   localparam logic [4:0] OPC_AND  = 5'd8;
   localparam logic [4:0] OPC_OR   = 5'd9;
   localparam logic [4:0] OPC_XOR  = 5'd10;
   localparam logic [4:0] OPC_LSR  = 5'd11;
   localparam logic [4:0] OPC_ASR  = 5'd12;
   localparam logic [4:0] OPC_SHL  = 5'd13;
   localparam logic [4:0] OPC_ROR  = 5'd14;
   localparam logic [4:0] OPC_BR   = 5'd15;
   localparam logic [4:0] OPC_BRL  = 5'd16;
   localparam logic [4:0] OPC_J    = 5'd17;
   localparam logic [4:0] OPC_JL   = 5'd18;
   localparam logic [4:0] OPC_LD   = 5'd19;
   localparam logic [4:0] OPC_LDR  = 5'd20;
   localparam logic [4:0] OPC_ST   = 5'd21;
   localparam logic [4:0] OPC_STR  = 5'd22;

   // A word address is backed by storage only when every bit above the
   // implemented index bits is zero.
   function automatic logic addr_in_range(input logic [IADDR_W-1:0] addr,
                                          input int aw);
      return (addr >> aw) == '0;
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// ---------------------------------------------------------------------------
// mem_rd_pipe
// Fixed-latency read return path. A read sampled at edge N appears on
// RD_DATA after edge N+RD_LAT-1. RD_LAT-1 intermediate {valid, data} stages
// feed an output register that only loads when a valid read arrives, so
// RD_DATA holds the last returned word while the pipe is idle.
//
// Ports:
//   CLK      in   clock
//   RSTN     in   asynchronous active-low reset, clears stages and output
//   IN_VALID in   a read is being sampled this cycle
//   IN_DATA  in   word read from storage (or the error word) this cycle
//   RD_DATA  out  returned read data
// ---------------------------------------------------------------------------
module mem_rd_pipe
   import risc_toy_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic            IN_VALID,
   input  logic [XLEN-1:0] IN_DATA,
   output logic [XLEN-1:0] RD_DATA
);

   generate
      if (RD_LAT <= 1) begin : g_direct
         // Single-cycle latency: the output register captures storage data
         // directly at the request edge.
         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               RD_DATA <= '0;
            end else if (IN_VALID) begin
               RD_DATA <= IN_DATA;
            end
         end
      end else begin : g_stages
         logic [RD_LAT-2:0] v_q;
         logic [XLEN-1:0]   d_q [RD_LAT-1];

         // Delay line: valid bits always shift, data only moves with a valid
         // read. The output register loads from the last stage only when it
         // carries a read, which gives the idle-hold behaviour.
         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               v_q <= '0;
               for (int i = 0; i < RD_LAT-1; i++) begin
                  d_q[i] <= '0;
               end
               RD_DATA <= '0;
            end else begin
               v_q[0] <= IN_VALID;
               if (IN_VALID) begin
                  d_q[0] <= IN_DATA;
               end
               for (int i = 1; i < RD_LAT-1; i++) begin
                  v_q[i] <= v_q[i-1];
                  if (v_q[i-1]) begin
                     d_q[i] <= d_q[i-1];
                  end
               end
               if (v_q[RD_LAT-2]) begin
                  RD_DATA <= d_q[RD_LAT-2];
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/risc_toy_mem_responder.sv
// ---------------------------------------------------------------------------
// risc_toy_mem_responder
// Unified word-addressed memory serving the RISC_TOY instruction fetch port
// and data port, with a fixed read latency, out-of-range detection and
// saturating data access counters. Storage is not reset.
//
// Parameters:
//   AW       implemented word-address bits, DEPTH = 2**AW words (AW < 30)
//   RD_LAT   read latency on both ports, 1..4
//   ERR_WORD read data returned for an out-of-range address
//
// Ports:
//   CLK     in   clock
//   RSTN    in   asynchronous active-low reset
//   IREQ    in   instruction fetch request
//   IADDR   in   instruction word address [29:0]
//   INSTR   out  fetched instruction [31:0]
//   DREQ    in   data access request
//   DRW     in   1 = write, 0 = read
//   DADDR   in   data word address [29:0]
//   DWDATA  in   write data [31:0]
//   DRDATA  out  read data [31:0]
//   ERR     out  sticky out-of-range flag, cleared only by reset
//   RD_CNT  out  saturating data-read counter [15:0]
//   WR_CNT  out  saturating data-write counter [15:0]
// ---------------------------------------------------------------------------
module risc_toy_mem_responder
   import risc_toy_pkg::*;
#(
   parameter int              AW       = 10,
   parameter int              RD_LAT   = 1,
   parameter logic [XLEN-1:0] ERR_WORD = ERR_WORD_DEFAULT
) (
   input  logic               CLK,
   input  logic               RSTN,
   input  logic               IREQ,
   input  logic [IADDR_W-1:0] IADDR,
   output logic [XLEN-1:0]    INSTR,
   input  logic               DREQ,
   input  logic               DRW,
   input  logic [IADDR_W-1:0] DADDR,
   input  logic [XLEN-1:0]    DWDATA,
   output logic [XLEN-1:0]    DRDATA,
   output logic               ERR,
   output logic [15:0]        RD_CNT,
   output logic [15:0]        WR_CNT
);

   localparam int DEPTH = 2**AW;

   logic [XLEN-1:0] mem [DEPTH];

   logic            i_in_range;
   logic            d_in_range;
   logic [AW-1:0]   i_idx;
   logic [AW-1:0]   d_idx;
   logic [XLEN-1:0] i_rdata;
   logic [XLEN-1:0] d_rdata;
   logic            d_rd;
   logic            d_wr;

   assign i_in_range = addr_in_range(IADDR, AW);
   assign d_in_range = addr_in_range(DADDR, AW);
   assign i_idx      = IADDR[AW-1:0];
   assign d_idx      = DADDR[AW-1:0];
   assign d_rd       = DREQ && !DRW;
   assign d_wr       = DREQ && DRW;

   // Reads are taken from the array before this edge's write lands, which
   // makes a same-cycle fetch/write collision read-first.
   assign i_rdata = i_in_range ? mem[i_idx] : ERR_WORD;
   assign d_rdata = d_in_range ? mem[d_idx] : ERR_WORD;

   // Storage write port; out-of-range writes are dropped rather than
   // aliased onto a low index.
   always_ff @(posedge CLK) begin
      if (d_wr && d_in_range) begin
         mem[d_idx] <= DWDATA;
      end
   end

   // Sticky error flag: any out-of-range request on either port sets it.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         ERR <= 1'b0;
      end else if ((IREQ && !i_in_range) || (DREQ && !d_in_range)) begin
         ERR <= 1'b1;
      end
   end

   // Data access counters, saturating at all-ones. Out-of-range accesses
   // are counted too; instruction fetches are not.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         RD_CNT <= '0;
         WR_CNT <= '0;
      end else begin
         if (d_rd && (RD_CNT != 16'hFFFF)) begin
            RD_CNT <= RD_CNT + 16'd1;
         end
         if (d_wr && (WR_CNT != 16'hFFFF)) begin
            WR_CNT <= WR_CNT + 16'd1;
         end
      end
   end

   mem_rd_pipe #(
      .RD_LAT (RD_LAT)
   ) u_ipipe (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .IN_VALID (IREQ),
      .IN_DATA  (i_rdata),
      .RD_DATA  (INSTR)
   );

   mem_rd_pipe #(
      .RD_LAT (RD_LAT)
   ) u_dpipe (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .IN_VALID (d_rd),
      .IN_DATA  (d_rdata),
      .RD_DATA  (DRDATA)
   );

endmodule

// File: tb/tb_risc_toy_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_risc_toy_mem_responder
// Directed bench for the memory responder. Two instances share every input:
// dut1 uses RD_LAT=1 and dut3 uses RD_LAT=3, so the same traffic exercises
// both latencies. Expected values are written out by hand below.
// ---------------------------------------------------------------------------
module tb_risc_toy_mem_responder;
   import risc_toy_pkg::*;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic        ireq;
   logic [29:0] iaddr;
   logic        dreq;
   logic        drw;
   logic [29:0] daddr;
   logic [31:0] dwdata;

   logic [31:0] instr1, drdata1, instr3, drdata3;
   logic        err1, err3;
   logic [15:0] rdcnt1, wrcnt1, rdcnt3, wrcnt3;

   int compareCount  = 0;
   int mismatchCount = 0;

   always #5 CLK = ~CLK;

   risc_toy_mem_responder #(.AW(10), .RD_LAT(1), .ERR_WORD(32'hDEAD_BEEF)) dut1 (
      .CLK(CLK), .RSTN(RSTN),
      .IREQ(ireq), .IADDR(iaddr), .INSTR(instr1),
      .DREQ(dreq), .DRW(drw), .DADDR(daddr), .DWDATA(dwdata), .DRDATA(drdata1),
      .ERR(err1), .RD_CNT(rdcnt1), .WR_CNT(wrcnt1)
   );

   risc_toy_mem_responder #(.AW(10), .RD_LAT(3), .ERR_WORD(32'hDEAD_BEEF)) dut3 (
      .CLK(CLK), .RSTN(RSTN),
      .IREQ(ireq), .IADDR(iaddr), .INSTR(instr3),
      .DREQ(dreq), .DRW(drw), .DADDR(daddr), .DWDATA(dwdata), .DRDATA(drdata3),
      .ERR(err3), .RD_CNT(rdcnt3), .WR_CNT(wrcnt3)
   );

   // Single comparison point: counts every check, reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of requests, then return 1 time unit after the edge.
   task automatic applyStimulus(input logic i_req, input logic [29:0] i_addr,
                                input logic d_req, input logic d_rw,
                                input logic [29:0] d_addr, input logic [31:0] d_wdata);
      ireq   = i_req;
      iaddr  = i_addr;
      dreq   = d_req;
      drw    = d_rw;
      daddr  = d_addr;
      dwdata = d_wdata;
      @(posedge CLK);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
   endtask

   task automatic applyReset();
      ireq = 1'b0; iaddr = '0; dreq = 1'b0; drw = 1'b0; daddr = '0; dwdata = '0;
      RSTN = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RSTN = 1'b1;
   endtask

   initial begin
      $display("[TB] start");
      applyReset();

      // Reset state
      checkOutput("rst_instr1",  instr1,  32'h0);
      checkOutput("rst_drdata1", drdata1, 32'h0);
      checkOutput("rst_err1",    err1,    32'h0);
      checkOutput("rst_rdcnt1",  rdcnt1,  32'h0);
      checkOutput("rst_wrcnt1",  wrcnt1,  32'h0);
      checkOutput("rst_drdata3", drdata3, 32'h0);

      // Write then read back next cycle
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b1, 30'd5, 32'h1234_5678);
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b0, 30'd5, 32'h0);
      checkOutput("t1_drdata1", drdata1, 32'h1234_5678);
      checkOutput("t1_drdata3_early", drdata3, 32'h0);
      checkOutput("t1_wrcnt1", wrcnt1, 32'd1);
      checkOutput("t1_rdcnt1", rdcnt1, 32'd1);
      idleCycle();
      checkOutput("t1_drdata3_lat2", drdata3, 32'h0);
      idleCycle();
      checkOutput("t1_drdata3_lat3", drdata3, 32'h1234_5678);

      // Pipelined reads, back to back
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b1, 30'd0, 32'hA0);
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b1, 30'd1, 32'hA1);
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b1, 30'd2, 32'hA2);
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b0, 30'd0, 32'h0);
      checkOutput("t2_r0_drdata3", drdata3, 32'h1234_5678);
      checkOutput("t2_r0_drdata1", drdata1, 32'hA0);
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b0, 30'd1, 32'h0);
      checkOutput("t2_r1_drdata3", drdata3, 32'h1234_5678);
      checkOutput("t2_r1_drdata1", drdata1, 32'hA1);
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b0, 30'd2, 32'h0);
      checkOutput("t2_r2_drdata3", drdata3, 32'hA0);
      checkOutput("t2_r2_drdata1", drdata1, 32'hA2);
      idleCycle();
      checkOutput("t2_i1_drdata3", drdata3, 32'hA1);
      idleCycle();
      checkOutput("t2_i2_drdata3", drdata3, 32'hA2);
      idleCycle();
      checkOutput("t2_hold_drdata3", drdata3, 32'hA2);
      checkOutput("t2_hold_drdata1", drdata1, 32'hA2);

      // Same-cycle fetch/write collision is read-first
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b1, 30'd7, 32'h1111_1111);
      applyStimulus(1'b1, 30'd7, 1'b1, 1'b1, 30'd7, 32'h2222_2222);
      checkOutput("t3_collide_instr1", instr1, 32'h1111_1111);
      applyStimulus(1'b1, 30'd7, 1'b0, 1'b0, 30'd0, 32'h0);
      checkOutput("t3_next_instr1", instr1, 32'h2222_2222);
      idleCycle();
      checkOutput("t3_collide_instr3", instr3, 32'h1111_1111);
      idleCycle();
      checkOutput("t3_next_instr3", instr3, 32'h2222_2222);
      checkOutput("t3_hold_instr1", instr1, 32'h2222_2222);

      // Out-of-range handling and sticky ERR
      applyReset();
      checkOutput("t4_err_clear", err1, 32'h0);
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b0, 30'h400, 32'h0);
      checkOutput("t4_oor_drdata1", drdata1, 32'hDEAD_BEEF);
      checkOutput("t4_oor_err1", err1, 32'h1);
      checkOutput("t4_oor_err3", err3, 32'h1);
      checkOutput("t4_oor_rdcnt1", rdcnt1, 32'd1);
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b1, 30'd3, 32'hCAFE_0003);
      applyStimulus(1'b0, 30'd0, 1'b0, 1'b1, 30'd3, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b0, 30'd3, 32'h0);
      checkOutput("t4_rd3_drdata1", drdata1, 32'hCAFE_0003);
      checkOutput("t4_err_sticky", err1, 32'h1);
      checkOutput("t4_wrcnt_ignored", wrcnt1, 32'd1);
      checkOutput("t4_rdcnt1", rdcnt1, 32'd2);
      applyStimulus(1'b1, 30'h3FFF_FFFF, 1'b1, 1'b1, 30'h3FF, 32'h0000_03FF);
      checkOutput("t4_oor_instr1", instr1, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 30'h3FF, 1'b1, 1'b1, 30'h400, 32'h5555_5555);
      checkOutput("t4_top_instr1", instr1, 32'h0000_03FF);
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b0, 30'd0, 32'h0);
      checkOutput("t4_no_alias", drdata1, 32'hA0);
      checkOutput("t4_wrcnt_oor", wrcnt1, 32'd3);

      // Write counter saturation
      applyReset();
      for (int i = 0; i < 65540; i++) begin
         applyStimulus(1'b0, 30'd0, 1'b1, 1'b1, 30'(i % 1024), 32'(i));
         if (i == 65533) checkOutput("t5_wrcnt_fffe", wrcnt1, 32'h0000_FFFE);
         if (i == 65534) checkOutput("t5_wrcnt_ffff", wrcnt1, 32'h0000_FFFF);
      end
      checkOutput("t5_wrcnt_sat", wrcnt1, 32'h0000_FFFF);
      checkOutput("t5_rdcnt", rdcnt1, 32'h0);

      // Reset with reads in flight
      applyReset();
      applyStimulus(1'b1, 30'h2000_0000, 1'b1, 1'b1, 30'd9, 32'h9999_0009);
      applyStimulus(1'b1, 30'd9, 1'b1, 1'b0, 30'd9, 32'h0);
      idleCycle();
      idleCycle();
      checkOutput("t6_pre_drdata3", drdata3, 32'h9999_0009);
      checkOutput("t6_pre_instr3", instr3, 32'h9999_0009);
      checkOutput("t6_pre_err3", err3, 32'h1);
      applyStimulus(1'b1, 30'd9, 1'b1, 1'b0, 30'd9, 32'h0);
      applyStimulus(1'b1, 30'd9, 1'b1, 1'b0, 30'd9, 32'h0);
      ireq = 1'b0; dreq = 1'b0; drw = 1'b0;
      RSTN = 1'b0;
      #1;
      checkOutput("t6_rst_instr3",  instr3,  32'h0);
      checkOutput("t6_rst_drdata3", drdata3, 32'h0);
      checkOutput("t6_rst_err3",    err3,    32'h0);
      checkOutput("t6_rst_rdcnt3",  rdcnt3,  32'h0);
      checkOutput("t6_rst_wrcnt3",  wrcnt3,  32'h0);
      checkOutput("t6_rst_drdata1", drdata1, 32'h0);
      @(negedge CLK);
      RSTN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idleCycle();
         checkOutput("t6_post_drdata3", drdata3, 32'h0);
         checkOutput("t6_post_instr3",  instr3,  32'h0);
      end
      applyStimulus(1'b0, 30'd0, 1'b1, 1'b0, 30'd9, 32'h0);
      idleCycle();
      checkOutput("t6_new_early", drdata3, 32'h0);
      idleCycle();
      checkOutput("t6_new_drdata3", drdata3, 32'h9999_0009);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/risc_toy_mem_responder.md
Name: risc_toy_mem_responder

Overview:
Memory-side responder for the RISC_TOY core. It terminates both core-initiated ports: the instruction fetch port (IREQ/IADDR/INSTR) and the data port (DREQ/DRW/DADDR/DWDATA/DRDATA). Both ports share one unified word-addressed storage array. The block is the system-level memory for simulation and FPGA bring-up. It adds a configurable read latency, out-of-range detection and access counters.

Parameters:
AW, 10, implemented word-address bits; DEPTH = 2**AW words of 32 bits
RD_LAT, 1, read latency in cycles on both ports; legal range 1..4
ERR_WORD, 32'hDEAD_BEEF, read data returned for an out-of-range address

Ports:
CLK  input  1  clock
RSTN  input  1  reset, asynchronous, active-low
IREQ  input  1  instruction fetch request
IADDR  input  30  instruction word address
INSTR  output  32  fetched instruction
DREQ  input  1  data access request
DRW  input  1  access direction: 1 = write, 0 = read
DADDR  input  30  data word address
DWDATA  input  32  write data
DRDATA  output  32  read data
ERR  output  1  sticky flag: an out-of-range access has occurred
RD_CNT  output  16  data-read counter, saturating
WR_CNT  output  16  data-write counter, saturating

Behaviour:
- Reset: RSTN is asynchronous, active-low; the clock is CLK. While RSTN is low:
  - INSTR=0, DRDATA=0, ERR=0, RD_CNT=0, WR_CNT=0.
  - All read pipeline stages and their valid bits are cleared.
  - Storage array contents are not reset.
- Address range check: an address is in range iff addr[29:AW]==0. Index = addr[AW-1:0].
- Data write (DREQ=1, DRW=1):
  - In range: mem[index] <= DWDATA at the rising edge.
  - Out of range: write dropped; ERR set.
  - WR_CNT increments by 1, saturating at 16'hFFFF. Out-of-range writes are counted.
- Data read (DREQ=1, DRW=0):
  - Data is sampled at edge N. It is visible on DRDATA after edge N+RD_LAT-1, i.e. stable for the core at edge N+RD_LAT.
  - Out of range: returns ERR_WORD and sets ERR.
  - RD_CNT increments by 1, saturating.
- Instruction read (IREQ=1): same timing as a data read, on INSTR. Out of range returns ERR_WORD and sets ERR. Instruction reads are not counted.
- Pipelining: one request per port per cycle, fully pipelined with no stalls. There is no ready signal; the core relies on the fixed latency.
- Idle hold: when a pipeline stage carries no valid read, the corresponding output holds its last value. Outputs change only when a valid read emerges from the last stage.
- Same-cycle collision: a data write and an instruction read of the same index in the same cycle are read-first. INSTR returns the old word; the new word is visible from the next fetch onward.
- Back-to-back data traffic: a write at edge N followed by a read of the same address at edge N+1 returns the new data.
- X-handling: DRW, DADDR and DWDATA are ignored when DREQ=0; IADDR is ignored when IREQ=0.
- ERR clears only on reset.
- Reset mid-operation: in-flight reads are discarded. After reset release, the outputs stay 0 until the first new read completes.

Decomposition:
- Shared package risc_toy_pkg:
  - XLEN=32, IADDR_W=30 and ERR_WORD default.
  - Opcode localparams, so the core and any testbench share one opcode table.
- Sub-module mem_rd_pipe:
  - Parameterised RD_LAT delay line, each stage holding {valid, data[31:0]}, with async reset.
  - Output register loads only when the last stage is valid.
  - Instantiated twice, once for INSTR and once for DRDATA.
- Storage array, range check and counters stay in the top module.

Test Plan:
1. RD_LAT=1. Write 32'h1234_5678 to DADDR=5, then read DADDR=5 the next cycle → DRDATA=32'h1234_5678 one cycle after the read request; WR_CNT=1, RD_CNT=1.
2. RD_LAT=3. Issue data reads to addresses 0,1,2 on consecutive cycles, after preloading them with 32'hA0, 32'hA1, 32'hA2 → DRDATA takes A0, A1, A2 on three consecutive cycles, starting 3 cycles after the first request; DRDATA holds A2 afterwards.
3. Preload IADDR=7 with 32'h1111_1111. In the same cycle, IREQ reads IADDR=7 and a data write of 32'h2222_2222 targets DADDR=7 → INSTR=32'h1111_1111. A fetch of IADDR=7 in the next cycle → 32'h2222_2222.
4. AW=10. Data read of DADDR=30'h400 → DRDATA=32'hDEAD_BEEF, ERR=1. A following in-range write to DADDR=3 leaves ERR=1 and is stored correctly.
5. Drive 65540 data writes → WR_CNT saturates at 16'hFFFF and does not wrap.
6. RD_LAT=3. Assert RSTN low while two reads are in flight → INSTR, DRDATA, ERR and both counters are 0 immediately. After release with no requests, the outputs stay 0 for at least 4 cycles.
